// File: rtl/cheat_pgm_loader.sv
// Collects 4-byte cheat words from the MCU and writes them into consecutive
// cheat slots, committing each word on a SNES bus-cycle boundary or on timeout.
module cheat_pgm_loader #(
    parameter logic [7:0] TIMEOUT  = 8'd255,
    parameter logic [2:0] LAST_IDX = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mcu_cmd_start,
    input  logic [2:0]  mcu_cmd_idx,
    input  logic [7:0]  mcu_data_in,
    input  logic        mcu_data_we,
    input  logic        mcu_cmd_end,
    input  logic        SNES_cycle_start,
    output logic [2:0]  pgm_idx,
    output logic [31:0] pgm_in,
    output logic        pgm_we,
    output logic        busy,
    output logic        err_overrun,
    output logic        err_partial,
    output logic        err_range
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // One past the last slot; the index is 4 bits so it can reach this without wrapping.
    localparam logic [3:0] END_IDX = {1'b0, LAST_IDX} + 4'd1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_idx;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_asm;
    logic        r_staged_valid;
    logic [31:0] r_staged_word;
    logic [2:0]  r_staged_idx;
    logic [7:0]  r_tmo_cnt;
    logic        r_pgm_we;
    logic [2:0]  r_pgm_idx;
    logic [31:0] r_pgm_in;
    logic        r_busy;
    logic        r_err_overrun;
    logic        r_err_partial;
    logic        r_err_range;

    logic        w_byte;
    logic        w_word_done;
    logic        w_commit;
    logic        w_stage;
    logic        w_overrun;
    logic        w_range;
    logic        w_partial;
    logic        w_start_oob;
    logic        w_staged_valid_nxt;
    logic        w_busy_nxt;

    // A start pulse overrides data/end pulses; the commit is held off for one clock after a strobe.
    assign w_byte      = (r_state == S_COLLECT) && mcu_data_we && !mcu_cmd_start && !mcu_cmd_end;
    assign w_word_done = w_byte && (r_byte_cnt == 2'd3);
    assign w_commit    = r_staged_valid && !r_pgm_we && !mcu_cmd_start &&
                         (SNES_cycle_start || (r_tmo_cnt == TIMEOUT));
    assign w_stage     = w_word_done && (!r_staged_valid || w_commit);
    assign w_overrun   = w_word_done && r_staged_valid && !w_commit;
    assign w_range     = (r_state == S_DONE) && mcu_data_we && !mcu_cmd_start && !mcu_cmd_end;
    assign w_partial   = (r_state != S_IDLE) && mcu_cmd_end && !mcu_cmd_start && (r_byte_cnt != 2'd0);
    assign w_start_oob = ({1'b0, mcu_cmd_idx} >= END_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (mcu_cmd_start) begin
                    w_state_nxt = w_start_oob ? S_DONE : S_COLLECT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (mcu_cmd_start) begin
                    w_state_nxt = w_start_oob ? S_DONE : S_COLLECT;
                end else if (mcu_cmd_end) begin
                    w_state_nxt = S_IDLE;
                end else if (w_word_done && ((r_idx + 4'd1) == END_IDX)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_DONE: begin
                if (mcu_cmd_start) begin
                    w_state_nxt = w_start_oob ? S_DONE : S_COLLECT;
                end else if (mcu_cmd_end) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next staging status and the busy flag it implies.
    always_comb begin
        w_staged_valid_nxt = r_staged_valid;
        if (mcu_cmd_start) begin
            w_staged_valid_nxt = 1'b0;
        end else if (w_stage) begin
            w_staged_valid_nxt = 1'b1;
        end else if (w_commit) begin
            w_staged_valid_nxt = 1'b0;
        end else begin
            w_staged_valid_nxt = r_staged_valid;
        end
        w_busy_nxt = (w_state_nxt != S_IDLE) || w_staged_valid_nxt;
    end

    // Staging register, commit strobe and timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_staged_valid <= 1'b0;
            r_staged_word  <= 32'h0000_0000;
            r_staged_idx   <= 3'd0;
            r_tmo_cnt      <= 8'd0;
            r_pgm_we       <= 1'b0;
            r_pgm_idx      <= 3'd0;
            r_pgm_in       <= 32'h0000_0000;
            r_busy         <= 1'b0;
        end else begin
            r_staged_valid <= w_staged_valid_nxt;
            r_busy         <= w_busy_nxt;
            r_pgm_we       <= w_commit;
            if (w_commit) begin
                r_pgm_idx <= r_staged_idx;
                r_pgm_in  <= r_staged_word;
            end
            if (w_stage) begin
                r_staged_word <= {r_asm, mcu_data_in};
                r_staged_idx  <= r_idx[2:0];
            end
            // The counter parks at TIMEOUT so a commit deferred by the strobe gap is not lost.
            if (mcu_cmd_start || w_stage || w_commit) begin
                r_tmo_cnt <= 8'd0;
            end else if (r_staged_valid && (r_tmo_cnt != TIMEOUT)) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end
    end

    // Session bookkeeping: slot index, byte assembly and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= 4'd0;
            r_byte_cnt    <= 2'd0;
            r_asm         <= 24'h00_0000;
            r_err_overrun <= 1'b0;
            r_err_partial <= 1'b0;
            r_err_range   <= 1'b0;
        end else if (mcu_cmd_start) begin
            r_idx         <= {1'b0, mcu_cmd_idx};
            r_byte_cnt    <= 2'd0;
            r_err_overrun <= 1'b0;
            r_err_partial <= 1'b0;
            r_err_range   <= 1'b0;
        end else begin
            if (w_byte) begin
                r_asm      <= {r_asm[15:0], mcu_data_in};
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (w_word_done) begin
                    r_idx <= r_idx + 4'd1;
                end
            end else if (w_partial) begin
                r_byte_cnt    <= 2'd0;
                r_err_partial <= 1'b1;
            end else if (mcu_cmd_end) begin
                r_byte_cnt <= 2'd0;
            end
            if (w_overrun) begin
                r_err_overrun <= 1'b1;
            end
            if (w_range) begin
                r_err_range <= 1'b1;
            end
        end
    end

    assign pgm_we      = r_pgm_we;
    assign pgm_idx     = r_pgm_idx;
    assign pgm_in      = r_pgm_in;
    assign busy        = r_busy;
    assign err_overrun = r_err_overrun;
    assign err_partial = r_err_partial;
    assign err_range   = r_err_range;

endmodule

// File: tb/tb_cheat_pgm_loader.sv
// Scoreboard bench for cheat_pgm_loader: expected commits are queued as words are
// sent and popped by a monitor whenever the loader strobes pgm_we.
module tb_cheat_pgm_loader;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mcu_cmd_start = 1'b0;
    logic [2:0]  mcu_cmd_idx = 3'd0;
    logic [7:0]  mcu_data_in = 8'h00;
    logic        mcu_data_we = 1'b0;
    logic        mcu_cmd_end = 1'b0;
    logic        SNES_cycle_start = 1'b0;
    logic [2:0]  pgm_idx;
    logic [31:0] pgm_in;
    logic        pgm_we;
    logic        busy;
    logic        err_overrun;
    logic        err_partial;
    logic        err_range;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_we = 0;
    int          cyc_n = 0;
    int          last_we_cyc = 0;
    logic        prev_we = 1'b0;
    logic [34:0] exp_q[$];

    cheat_pgm_loader dut (
        .clk(clk), .rst(rst),
        .mcu_cmd_start(mcu_cmd_start), .mcu_cmd_idx(mcu_cmd_idx),
        .mcu_data_in(mcu_data_in), .mcu_data_we(mcu_data_we),
        .mcu_cmd_end(mcu_cmd_end), .SNES_cycle_start(SNES_cycle_start),
        .pgm_idx(pgm_idx), .pgm_in(pgm_in), .pgm_we(pgm_we), .busy(busy),
        .err_overrun(err_overrun), .err_partial(err_partial), .err_range(err_range)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected commit.
    always @(negedge clk) begin
        if (!rst && pgm_we) begin
            n_we++;
            last_we_cyc = cyc_n;
            check_eq("we_not_consecutive", {31'd0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_we", 32'd1, 32'd0);
            end else begin
                logic [34:0] e;
                e = exp_q.pop_front();
                check_eq("pgm_idx", {29'd0, pgm_idx}, {29'd0, e[34:32]});
                check_eq("pgm_in", pgm_in, e[31:0]);
            end
        end
        prev_we = rst ? 1'b0 : pgm_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_s(input logic [2:0] idx);
        mcu_cmd_start = 1'b1;
        mcu_cmd_idx   = idx;
        tick();
        mcu_cmd_start = 1'b0;
    endtask

    task automatic end_s();
        mcu_cmd_end = 1'b1;
        tick();
        mcu_cmd_end = 1'b0;
    endtask

    task automatic snes();
        SNES_cycle_start = 1'b1;
        tick();
        SNES_cycle_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        mcu_data_in = b;
        mcu_data_we = 1'b1;
        tick();
        mcu_data_we = 1'b0;
    endtask

    task automatic send_word(input logic [2:0] idx, input logic [31:0] w, input bit push);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        if (push) exp_q.push_back({idx, w});
        send_byte(w[7:0]);
    endtask

    task automatic wait_we(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && n_we < target; i++) tick();
        check_eq(tag, n_we, target);
    endtask

    initial begin
        int          base;
        int          stage_cyc;
        logic [31:0] wacc;
        logic [7:0]  b;

        // Reset state
        #1;
        check_eq("rst_pgm_we", {31'd0, pgm_we}, 32'd0);
        check_eq("rst_pgm_in", pgm_in, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_errs", {29'd0, err_overrun, err_partial, err_range}, 32'd0);
        tick();
        rst = 1'b0;

        // Basic write
        base = n_we;
        start_s(3'd2);
        send_word(3'd2, 32'h00FF_EA5C, 1'b1);
        end_s();
        tick();
        snes();
        wait_we(base + 1, 10, "basic_pulse");
        ticks(3);
        check_eq("basic_count", n_we, base + 1);
        check_eq("basic_busy", {31'd0, busy}, 32'd0);
        check_eq("hold_pgm_in", pgm_in, 32'h00FF_EA5C);
        check_eq("hold_pgm_idx", {29'd0, pgm_idx}, 32'd2);

        // Full sweep: a byte every 2 clocks, cycle start every 6 clocks
        base = n_we;
        start_s(3'd0);
        wacc = 32'd0;
        for (int c = 0; c < 80; c++) begin
            int k;
            k = c / 2;
            mcu_data_we      = ((c % 2) == 0) && (k < 33);
            SNES_cycle_start = ((c % 6) == 5);
            b = 8'(k * 13 + 5);
            mcu_data_in = b;
            if (mcu_data_we && k < 32) begin
                wacc = {wacc[23:0], b};
                if ((k % 4) == 3) exp_q.push_back({3'(k / 4), wacc});
            end
            tick();
        end
        mcu_data_we = 1'b0;
        SNES_cycle_start = 1'b0;
        ticks(4);
        check_eq("sweep_count", n_we, base + 8);
        check_eq("sweep_err_range", {31'd0, err_range}, 32'd1);
        check_eq("sweep_no_overrun", {31'd0, err_overrun}, 32'd0);
        end_s();

        // Timeout commit
        base = n_we;
        start_s(3'd3);
        send_word(3'd3, 32'hDEAD_BEEF, 1'b1);
        stage_cyc = cyc_n;
        wait_we(base + 1, TMO + 20, "tmo_pulse");
        check_eq("tmo_latency", last_we_cyc - stage_cyc, TMO + 1);
        end_s();

        // Overrun
        base = n_we;
        start_s(3'd4);
        send_word(3'd4, 32'h1122_3344, 1'b1);
        send_word(3'd5, 32'h5566_7788, 1'b0);
        wait_we(base + 1, TMO + 20, "ovr_first");
        check_eq("ovr_flag", {31'd0, err_overrun}, 32'd1);
        send_word(3'd6, 32'h99AA_BBCC, 1'b1);
        snes();
        wait_we(base + 2, 10, "ovr_next_idx");
        end_s();

        // Partial and abort
        base = n_we;
        start_s(3'd0);
        send_byte(8'hA1);
        send_byte(8'hA2);
        end_s();
        snes();
        ticks(4);
        check_eq("partial_flag", {31'd0, err_partial}, 32'd1);
        check_eq("partial_no_we", n_we, base);
        start_s(3'd5);
        send_byte(8'hB1);
        send_byte(8'hB2);
        send_byte(8'hB3);
        start_s(3'd1);
        check_eq("abort_clears_partial", {31'd0, err_partial}, 32'd0);
        send_word(3'd1, 32'hC0DE_F00D, 1'b1);
        snes();
        wait_we(base + 1, 10, "abort_pulse");
        end_s();
        ticks(3);
        check_eq("abort_single", n_we, base + 1);

        // Asynchronous reset with a staged word
        base = n_we;
        start_s(3'd2);
        send_word(3'd2, 32'h7777_8888, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_pgm_in", pgm_in, 32'd0);
        check_eq("arst_pgm_idx", {29'd0, pgm_idx}, 32'd0);
        check_eq("arst_busy_we", {30'd0, busy, pgm_we}, 32'd0);
        check_eq("arst_errs", {29'd0, err_overrun, err_partial, err_range}, 32'd0);
        tick();
        rst = 1'b0;
        snes();
        ticks(TMO + 10);
        check_eq("arst_no_we", n_we, base);
        check_eq("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cheat_pgm_loader.md
CHEAT_PGM_LOADER -- requirements
Module: cheat_pgm_loader

Interface
REQ-001 Parameter TIMEOUT, default 8'd255: clocks to wait for a SNES cycle boundary before a staged word commits anyway.
REQ-002 Parameter LAST_IDX, default 3'd7: highest programmable slot index.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 mcu_cmd_start  input  1  one-clock pulse that opens a programming session.
REQ-006 mcu_cmd_idx  input  3  first slot index, sampled with mcu_cmd_start.
REQ-007 mcu_data_in  input  8  MCU payload byte.
REQ-008 mcu_data_we  input  1  one-clock strobe; mcu_data_in is valid.
REQ-009 mcu_cmd_end  input  1  one-clock pulse that closes the session.
REQ-010 SNES_cycle_start  input  1  one-clock pulse at each SNES bus cycle start.
REQ-011 pgm_idx  output  3  slot index for the downstream cheat unit.
REQ-012 pgm_in  output  32  word for the downstream cheat unit: {addr[23:0], data[7:0]} or flag word.
REQ-013 pgm_we  output  1  one-clock write strobe.
REQ-014 busy  output  1  high in any state other than IDLE, or while a word is staged.
REQ-015 err_overrun  output  1  sticky: a word completed while the staging register was still full.
REQ-016 err_partial  output  1  sticky: a session ended with 1-3 bytes collected.
REQ-017 err_range  output  1  sticky: a byte arrived after slot LAST_IDX was consumed.

Function
REQ-018 States: IDLE, COLLECT, DONE; a separate staging register (staged_valid, staged_word, staged_idx) commits independently of the state.
REQ-019 IDLE: mcu_data_we and mcu_cmd_end are ignored. mcu_cmd_start moves to COLLECT, loads the index, clears byte_cnt and all three error flags, and discards any staged word.
REQ-020 COLLECT: each mcu_data_we shifts the byte in MSB-first into assembly word asm[31:0] and increments the 2-bit byte_cnt.
REQ-021 4th byte at cycle N: staged_word = {asm[23:0], byte} and staged_idx = current index at N+1; the index increments and byte_cnt wraps to 0.
REQ-022 Index reaching LAST_IDX+1 (no 3-bit wrap to 0): state goes to DONE; later bytes set err_range and are dropped.
REQ-023 Commit: staged word is held until SNES_cycle_start is seen at cycle M; pgm_we=1 at M+1 for exactly one clock, with pgm_idx and pgm_in valid in the same clock; staged_valid clears at M+1.
REQ-024 Timeout: an 8-bit counter runs while staged_valid=1 and clears on staging. When the count reaches TIMEOUT with no SNES_cycle_start, the word commits on the next clock.
REQ-025 Overrun: if a word completes while staged_valid=1 and no commit happens in the same clock, the new word is dropped, err_overrun=1, and the index still increments.
REQ-026 If a word completes in the same clock as a commit strobe is generated, the new word is staged and there is no overrun.
REQ-027 mcu_cmd_end in COLLECT or DONE: go to IDLE. If byte_cnt!=0, set err_partial and discard the partial bytes. A staged word still commits.
REQ-028 mcu_cmd_start in COLLECT or DONE restarts the session per REQ-019 (abort). mcu_cmd_start takes priority over mcu_data_we and mcu_cmd_end in the same clock.
REQ-029 pgm_we never asserts in two consecutive clocks.
REQ-030 pgm_in and pgm_idx hold their last committed value when pgm_we=0.

Reset
REQ-031 rst=1 immediately forces the following, independent of clk:
- state=IDLE, staged_valid=0, byte_cnt=0, timeout counter=0;
- pgm_we=0, pgm_idx=0, pgm_in=0, busy=0, all err_*=0.
REQ-032 A reset during a pending commit discards the word, and no pgm_we is produced after release.
REQ-033 The first clock edge after rst deasserts performs normal operation; no warm-up cycles.

Verification
REQ-034 Basic write: start idx=2, bytes 00 FF EA 5C, SNES_cycle_start 3 clocks later:
- one pgm_we pulse with pgm_idx=2, pgm_in=32'h00FFEA5C;
- busy=0 after commit.
REQ-035 Full sweep: start idx=0, 32 bytes, cycle_start every 6 clocks:
- 8 pulses with idx 0..7 in order;
- a 33rd byte sets err_range=1 and produces no pulse.
REQ-036 Timeout: stage a word with SNES_cycle_start held 0 -> pgm_we asserts exactly TIMEOUT+1 clocks after staging.
REQ-037 Overrun: 8 bytes back-to-back with no cycle_start:
- first word commits on timeout;
- second word dropped, err_overrun=1;
- next staged word uses idx start+2.
REQ-038 Partial and abort: 2 bytes then cmd_end -> err_partial=1, no pgm_we. Start idx=5, 3 bytes, start idx=1, 4 bytes -> single pulse at idx=1.
REQ-039 Async reset: assert rst mid-clock while a word is staged -> outputs zero immediately, and no pgm_we appears afterwards.
